// File: rtl/atm_keypad_frontend_if.sv
// Signal bundle between the customer keypad/card slot and the ATM controller inputs.
// slave: the front end itself; master: the raw keypad/card-slot side.
interface atm_keypad_frontend_if;
  logic        cardDetect;
  logic        keyPressed;
  logic [3:0]  keyCode;
  logic        receivedCard;
  logic        transType;
  logic        stbTransaction;
  logic        stbDigit;
  logic [3:0]  digit;
  logic        stbAmount;
  logic [31:0] amount;

  modport slave (
    input  cardDetect, keyPressed, keyCode,
    output receivedCard, transType, stbTransaction, stbDigit, digit, stbAmount, amount
  );

  modport master (
    output cardDetect, keyPressed, keyCode,
    input  receivedCard, transType, stbTransaction, stbDigit, digit, stbAmount, amount
  );
endinterface

// File: rtl/atm_keypad_frontend.sv
// Customer-side ATM front end: synchronizes card/keypad, debounces key presses and
// turns them into PIN digit, transaction and amount strobes for the controller.
module atm_keypad_frontend #(
  parameter int unsigned DEBOUNCE      = 4,
  parameter int unsigned PIN_DIGITS    = 4,
  parameter int unsigned AMOUNT_DIGITS = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  atm_keypad_frontend_if.slave  bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);
  localparam int unsigned PIN_W = $clog2(PIN_DIGITS + 1);
  localparam int unsigned AMT_W = $clog2(AMOUNT_DIGITS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PIN, ST_SELECT, ST_AMOUNT} state_e;

  logic             card_s1_q, card_s2_q, card_d_q;
  logic             key_s1_q, key_s2_q;
  logic [3:0]       code_s1_q, code_s2_q;

  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             armed_q, armed_d;
  logic             evt_q, evt_d;
  logic [3:0]       evt_code_q, evt_code_d;

  state_e           state_q, state_d;
  logic [PIN_W-1:0] pin_cnt_q, pin_cnt_d;
  logic [AMT_W-1:0] amt_cnt_q, amt_cnt_d;
  logic [31:0]      amount_q, amount_d;
  logic [3:0]       digit_q, digit_d;
  logic             trans_q, trans_d;
  logic             stb_digit_q, stb_digit_d;
  logic             stb_trans_q, stb_trans_d;
  logic             stb_amt_q, stb_amt_d;
  logic             card_lost_c;

  // Two-flop synchronizers plus a delayed copy of card presence for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      card_s1_q <= 1'b0;
      card_s2_q <= 1'b0;
      card_d_q  <= 1'b0;
      key_s1_q  <= 1'b0;
      key_s2_q  <= 1'b0;
      code_s1_q <= 4'd0;
      code_s2_q <= 4'd0;
    end else begin
      card_s1_q <= bus.cardDetect;
      card_s2_q <= card_s1_q;
      card_d_q  <= card_s2_q;
      key_s1_q  <= bus.keyPressed;
      key_s2_q  <= key_s1_q;
      code_s1_q <= bus.keyCode;
      code_s2_q <= code_s1_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_cnt_q    <= '0;
      armed_q     <= 1'b1;
      evt_q       <= 1'b0;
      evt_code_q  <= 4'd0;
      state_q     <= ST_IDLE;
      pin_cnt_q   <= '0;
      amt_cnt_q   <= '0;
      amount_q    <= 32'd0;
      digit_q     <= 4'd0;
      trans_q     <= 1'b0;
      stb_digit_q <= 1'b0;
      stb_trans_q <= 1'b0;
      stb_amt_q   <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      armed_q     <= armed_d;
      evt_q       <= evt_d;
      evt_code_q  <= evt_code_d;
      state_q     <= state_d;
      pin_cnt_q   <= pin_cnt_d;
      amt_cnt_q   <= amt_cnt_d;
      amount_q    <= amount_d;
      digit_q     <= digit_d;
      trans_q     <= trans_d;
      stb_digit_q <= stb_digit_d;
      stb_trans_q <= stb_trans_d;
      stb_amt_q   <= stb_amt_d;
    end
  end

  assign card_lost_c = (state_q != ST_IDLE) && !card_s2_q;

  always_comb begin
    db_cnt_d    = db_cnt_q;
    armed_d     = armed_q;
    evt_d       = 1'b0;
    evt_code_d  = evt_code_q;
    state_d     = state_q;
    pin_cnt_d   = pin_cnt_q;
    amt_cnt_d   = amt_cnt_q;
    amount_d    = amount_q;
    digit_d     = digit_q;
    trans_d     = trans_q;
    stb_digit_d = 1'b0;
    stb_trans_d = 1'b0;
    stb_amt_d   = 1'b0;

    // armed_q is the key level being waited for: 1 = press, 0 = release
    if (key_s2_q == armed_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
        db_cnt_d = '0;
        armed_d  = !armed_q;
        evt_d    = armed_q;
        if (armed_q) evt_code_d = code_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (card_s2_q && !card_d_q) begin
          state_d   = ST_PIN;
          pin_cnt_d = '0;
        end
      end
      ST_PIN: begin
        if (evt_q && evt_code_q <= 4'd9) begin
          digit_d     = evt_code_q;
          stb_digit_d = 1'b1;
          if (pin_cnt_q == PIN_W'(PIN_DIGITS - 1)) begin
            state_d   = ST_SELECT;
            pin_cnt_d = '0;
          end else begin
            pin_cnt_d = pin_cnt_q + PIN_W'(1);
          end
        end
      end
      ST_SELECT: begin
        if (evt_q && (evt_code_q == 4'hA || evt_code_q == 4'hB)) begin
          trans_d     = evt_code_q[0];
          stb_trans_d = 1'b1;
          state_d     = ST_AMOUNT;
          amount_d    = 32'd0;
          amt_cnt_d   = '0;
        end
      end
      ST_AMOUNT: begin
        if (evt_q) begin
          if (evt_code_q <= 4'd9) begin
            if (amt_cnt_q < AMT_W'(AMOUNT_DIGITS)) begin
              amount_d  = amount_q * 32'd10 + 32'(evt_code_q);
              amt_cnt_d = amt_cnt_q + AMT_W'(1);
            end
          end else if (evt_code_q == 4'hD) begin
            amount_d  = 32'd0;
            amt_cnt_d = '0;
          end else if (evt_code_q == 4'hC && amt_cnt_q != '0) begin
            stb_amt_d = 1'b1;
            state_d   = ST_SELECT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Card removal overrides everything, including a key event in the same cycle
    if (card_lost_c) begin
      state_d     = ST_IDLE;
      pin_cnt_d   = '0;
      amt_cnt_d   = '0;
      db_cnt_d    = '0;
      armed_d     = 1'b1;
      evt_d       = 1'b0;
      amount_d    = amount_q;
      digit_d     = digit_q;
      trans_d     = trans_q;
      stb_digit_d = 1'b0;
      stb_trans_d = 1'b0;
      stb_amt_d   = 1'b0;
    end
  end

  assign bus.receivedCard   = card_s2_q;
  assign bus.transType      = trans_q;
  assign bus.stbTransaction = stb_trans_q;
  assign bus.stbDigit       = stb_digit_q;
  assign bus.digit          = digit_q;
  assign bus.stbAmount      = stb_amt_q;
  assign bus.amount         = amount_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Bench for atm_keypad_frontend: directed card/keypad sessions followed by random key
// sequences, checked against a transaction-level model of the customer dialogue.
module tb_atm_keypad_frontend;

  localparam int unsigned DB    = 4;
  localparam int unsigned PIN_N = 4;
  localparam int unsigned AMT_N = 9;

  localparam int P_OFF = 0;
  localparam int P_PIN = 1;
  localparam int P_SEL = 2;
  localparam int P_AMT = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  atm_keypad_frontend_if bus();

  atm_keypad_frontend #(
    .DEBOUNCE      (DB),
    .PIN_DIGITS    (PIN_N),
    .AMOUNT_DIGITS (AMT_N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running edge counter and strobe log
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [2:0]  ev_kind [0:1023];
  logic [31:0] ev_val  [0:1023];
  int unsigned ev_cyc  [0:1023];
  int unsigned ev_wr = 0;

  always @(negedge clock) begin
    if (bus.stbDigit || bus.stbTransaction || bus.stbAmount) begin
      ev_kind[ev_wr[9:0]] <= {bus.stbAmount, bus.stbTransaction, bus.stbDigit};
      ev_val[ev_wr[9:0]]  <= bus.stbDigit ? 32'(bus.digit) :
                             bus.stbTransaction ? 32'(bus.transType) : bus.amount;
      ev_cyc[ev_wr[9:0]]  <= cyc;
      ev_wr               <= ev_wr + 1;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rd    = 0;

  // Customer-dialogue model
  int          m_phase  = P_OFF;
  int          m_pins   = 0;
  int          m_adig   = 0;
  longint      m_amount = 0;
  int          m_digit  = 0;
  int          m_tt     = 0;
  logic        m_card   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_key(input int c, output logic [2:0] kind, output logic [31:0] val);
    kind = 3'b000;
    val  = 32'd0;
    if (m_phase == P_PIN && c <= 9) begin
      m_digit = c;
      m_pins  = m_pins + 1;
      kind = 3'b001; val = 32'(c);
      if (m_pins == PIN_N) m_phase = P_SEL;
    end else if (m_phase == P_SEL && (c == 10 || c == 11)) begin
      m_tt = c - 10;
      kind = 3'b010; val = 32'(m_tt);
      m_phase = P_AMT; m_amount = 0; m_adig = 0;
    end else if (m_phase == P_AMT) begin
      if (c <= 9) begin
        if (m_adig < AMT_N) begin
          m_amount = m_amount * 10 + c;
          m_adig   = m_adig + 1;
        end
      end else if (c == 13) begin
        m_amount = 0; m_adig = 0;
      end else if (c == 12 && m_adig > 0) begin
        kind = 3'b100; val = 32'(m_amount);
        m_phase = P_SEL;
      end
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, ".card"},   32'(bus.receivedCard), 32'(m_card));
    check({tag, ".digit"},  32'(bus.digit),        32'(m_digit));
    check({tag, ".ttype"},  32'(bus.transType),    32'(m_tt));
    check({tag, ".amount"}, bus.amount,            32'(m_amount));
  endtask

  task automatic expect_after(input string tag, input int unsigned t0,
                              input logic [2:0] kind, input logic [31:0] val);
    int unsigned n;
    n = ev_wr - rd;
    check({tag, ".count"}, n, (kind == 3'b000) ? 32'd0 : 32'd1);
    if (n != 0 && kind != 3'b000) begin
      check({tag, ".kind"},  32'(ev_kind[rd[9:0]]), 32'(kind));
      check({tag, ".value"}, ev_val[rd[9:0]], val);
      check({tag, ".lat"},   ev_cyc[rd[9:0]] - t0, DB + 3);
    end
    rd = ev_wr;
  endtask

  // One clean key press: code held for hold edges, then released for rel edges
  task automatic do_key(input string tag, input int c, input int hold, input int rel);
    int unsigned t0;
    logic [2:0]  kind;
    logic [31:0] val;
    bus.keyCode    = 4'(c);
    bus.keyPressed = 1'b1;
    t0 = cyc;
    tick(hold);
    bus.keyPressed = 1'b0;
    tick(rel);
    model_key(c, kind, val);
    expect_after(tag, t0, kind, val);
    check_held(tag);
  endtask

  task automatic key(input string tag, input int c);
    do_key(tag, c, 10, 10);
  endtask

  task automatic set_card(input string tag, input logic lvl);
    logic prev;
    prev = bus.receivedCard;
    bus.cardDetect = lvl;
    @(negedge clock);
    @(negedge clock);
    check({tag, ".lat1"}, 32'(bus.receivedCard), 32'(prev));
    @(negedge clock);
    check({tag, ".lat2"}, 32'(bus.receivedCard), 32'(lvl));
    tick(4);
    m_card = lvl;
    if (lvl) begin
      m_phase = P_PIN; m_pins = 0;
    end else begin
      m_phase = P_OFF;
    end
  endtask

  task automatic bounce(input string tag, input int c);
    int unsigned t0;
    logic [2:0]  kind;
    logic [31:0] val;
    bus.keyCode = 4'(c);
    for (int i = 0; i < 2; i++) begin
      bus.keyPressed = 1'b1; tick(2);
      bus.keyPressed = 1'b0; tick(2);
    end
    bus.keyPressed = 1'b1;
    t0 = cyc;
    tick(20);
    bus.keyPressed = 1'b0;
    tick(10);
    model_key(c, kind, val);
    expect_after(tag, t0, kind, val);
    check_held(tag);
  endtask

  initial begin
    int r;
    bus.cardDetect = 1'b0;
    bus.keyPressed = 1'b0;
    bus.keyCode    = 4'd0;
    tick(3);
    check("rst.stbDigit", 32'(bus.stbDigit), 32'd0);
    check("rst.stbTrans", 32'(bus.stbTransaction), 32'd0);
    check("rst.stbAmount", 32'(bus.stbAmount), 32'd0);
    check_held("rst");
    reset = 1'b1;
    tick(3);

    set_card("ins1", 1'b1);
    key("pin1", 1);
    key("pin2", 2);
    key("pin3", 3);
    key("pin4", 4);
    key("selB", 11);
    key("amt2", 2);
    key("amt5", 5);
    key("amt0", 0);
    key("amtC", 12);
    check("amt250", bus.amount, 32'd250);

    key("selDigitIgnored", 5);
    key("selA", 10);
    for (int i = 0; i < 12; i++) key("nines", 9);
    check("amt999999999", bus.amount, 32'd999999999);
    key("clr", 13);
    check("amtCleared", bus.amount, 32'd0);
    key("enterEmpty", 12);
    key("amt3", 3);
    key("enter3", 12);

    set_card("pull1", 1'b0);
    key("offKey", 5);
    set_card("ins2", 1'b1);
    key("p2a", 1);
    key("p2b", 2);
    set_card("pull2", 1'b0);
    key("offKey2", 3);
    set_card("ins3", 1'b1);
    bounce("bounce", 8);
    do_key("held7", 7, 100, 10);
    key("p3c", 14);
    key("p3d", 6);
    key("p3e", 0);
    key("selA2", 10);
    key("m4", 4);
    key("m2", 2);

    // Asynchronous reset while a press is about to be accepted
    bus.keyCode    = 4'd6;
    bus.keyPressed = 1'b1;
    tick(5);
    #2 reset = 1'b0;
    #1;
    check("arst.stbDigit", 32'(bus.stbDigit), 32'd0);
    check("arst.stbTrans", 32'(bus.stbTransaction), 32'd0);
    check("arst.stbAmount", 32'(bus.stbAmount), 32'd0);
    check("arst.card", 32'(bus.receivedCard), 32'd0);
    check("arst.digit", 32'(bus.digit), 32'd0);
    check("arst.ttype", 32'(bus.transType), 32'd0);
    check("arst.amount", bus.amount, 32'd0);
    tick(4);
    bus.keyPressed = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(12);
    check("arst.noStrobe", ev_wr - rd, 32'd0);
    rd = ev_wr;
    m_phase = P_PIN; m_pins = 0; m_adig = 0;
    m_amount = 0; m_digit = 0; m_tt = 0;
    check_held("arst.after");

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 19) set_card("rnd.card", !m_card);
      else if (r < 11) do_key("rnd", int'($urandom_range(0, 9)),
                              DB + 2 + int'($urandom_range(0, 6)), DB + 4 + int'($urandom_range(0, 6)));
      else if (r < 14) do_key("rnd", 10 + int'($urandom_range(0, 1)), DB + 2, DB + 4);
      else if (r < 17) do_key("rnd", 12, DB + 3, DB + 5);
      else if (r == 17) do_key("rnd", 13, DB + 2, DB + 4);
      else do_key("rnd", 14 + int'($urandom_range(0, 1)), DB + 2, DB + 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
